sign_compress: RTL and testbench

SIGN_COMPRESS -- requirements
Module: sign_compress

---
 rtl/sign_compress_pkg.sv | 17 +
 rtl/sign_compress_fit.sv | 15 +
 rtl/sign_compress.sv | 95 +++++++++
 tb/tb_sign_compress.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sign_compress_pkg.sv
// Shared definitions for the sign_compress block.
//   state_t : output FSM states (EMPTY, SHORT, HI, LO)
//   WORD_W  : width of an input word
//   HALF_W  : width of an output beat
package sign_compress_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SHORT = 2'd1,
    HI    = 2'd2,
    LO    = 2'd3
  } state_t;

endpackage

// File: rtl/sign_compress_fit.sv
// Combinational fit predicate for sign_compress.
//   in_data : 32-bit signed word
//   fits    : 1 when sign-extending in_data[15:0] reproduces in_data exactly
module sign_fit_check
  import sign_compress_pkg::*;
(
  input  logic [WORD_W-1:0] in_data,
  output logic              fits
);

  always_comb begin
    fits = (in_data[WORD_W-1:HALF_W] == {HALF_W{in_data[HALF_W-1]}});
  end

endmodule

// File: rtl/sign_compress.sv
// Narrows a stream of 32-bit signed words onto a 16-bit beat stream.
// Words that survive a 16-to-32 sign extension go out as one short beat;
// all others go out as two beats, high half first.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : input handshake, in_data is the 32-bit word
//   out_valid/out_ready   : output handshake, out_data is the 16-bit beat
//   out_short             : beat is a whole word in short form
//   out_last              : beat is the final beat of its word
//   cnt_short / cnt_long  : saturating counts of words sent in each form
module sign_compress
  import sign_compress_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter bit          COMPRESS_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HALF_W-1:0] out_data,
  output logic              out_short,
  output logic              out_last,
  output logic [CNT_W-1:0]  cnt_short,
  output logic [CNT_W-1:0]  cnt_long
);

  state_t            state;
  logic [HALF_W-1:0] lo_half;
  logic              fits;
  logic              accept;
  logic              go_short;

  sign_fit_check u_fit (
    .in_data (in_data),
    .fits    (fits)
  );

  // A new word may be taken while the final beat of the previous one leaves,
  // which gives back-to-back short words and two-cycle long words.
  always_comb begin
    in_ready  = (state == EMPTY) ||
                (((state == SHORT) || (state == LO)) && out_ready);
    accept    = in_valid && in_ready;
    go_short  = fits && COMPRESS_EN;
    out_valid = (state != EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_data  <= '0;
      out_short <= 1'b0;
      out_last  <= 1'b0;
      lo_half   <= '0;
      cnt_short <= '0;
      cnt_long  <= '0;
    end else if (accept) begin
      if (go_short) begin
        state     <= SHORT;
        out_data  <= in_data[HALF_W-1:0];
        out_short <= 1'b1;
        out_last  <= 1'b1;
        if (cnt_short != '1) cnt_short <= cnt_short + CNT_W'(1);
      end else begin
        state     <= HI;
        out_data  <= in_data[WORD_W-1:HALF_W];
        out_short <= 1'b0;
        out_last  <= 1'b0;
        lo_half   <= in_data[HALF_W-1:0];
        if (cnt_long != '1) cnt_long <= cnt_long + CNT_W'(1);
      end
    end else begin
      case (state)
        HI: begin
          if (out_ready) begin
            state     <= LO;
            out_data  <= lo_half;
            out_short <= 1'b0;
            out_last  <= 1'b1;
          end
        end
        SHORT, LO: begin
          if (out_ready) state <= EMPTY;
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sign_compress.sv
// Directed self-checking bench for sign_compress.
// u_dut uses default parameters; u_dut2 runs long-form only with 2-bit counters.
module tb_sign_compress;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, out_short, out_last;
  logic [31:0] in_data;
  logic [15:0] out_data;
  logic [15:0] cnt_short, cnt_long;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, out_short2, out_last2;
  logic [31:0] in_data2;
  logic [15:0] out_data2;
  logic [1:0]  cnt_short2, cnt_long2;

  int n_checks = 0;
  int n_fail   = 0;

  sign_compress u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_short (out_short),
    .out_last  (out_last),
    .cnt_short (cnt_short),
    .cnt_long  (cnt_long)
  );

  sign_compress #(
    .CNT_W       (2),
    .COMPRESS_EN (1'b0)
  ) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .in_data   (in_data2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .out_data  (out_data2),
    .out_short (out_short2),
    .out_last  (out_last2),
    .cnt_short (cnt_short2),
    .cnt_long  (cnt_long2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input logic [15:0] d, input logic s, input logic l);
    check_val({tag, ".valid"}, 32'(out_valid), 32'd1);
    check_val({tag, ".data"},  32'(out_data),  32'(d));
    check_val({tag, ".short"}, 32'(out_short), 32'(s));
    check_val({tag, ".last"},  32'(out_last),  32'(l));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0;
    tick();
    tick();

    // reset state
    check_val("rst.out_valid", 32'(out_valid), 32'd0);
    check_val("rst.out_data",  32'(out_data),  32'd0);
    check_val("rst.out_short", 32'(out_short), 32'd0);
    check_val("rst.out_last",  32'(out_last),  32'd0);
    check_val("rst.cnt_short", 32'(cnt_short), 32'd0);
    check_val("rst.cnt_long",  32'(cnt_long),  32'd0);
    rst_n = 1'b1;
    #1;
    check_val("rel.in_ready", 32'(in_ready), 32'd1);

    // 0x0000_7FFF fits
    in_valid = 1'b1; in_data = 32'h0000_7FFF; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check_beat("s1", 16'h7FFF, 1'b1, 1'b1);
    check_val("s1.cnt_short", 32'(cnt_short), 32'd1);
    tick();
    check_val("s1.idle", 32'(out_valid), 32'd0);

    // 0xFFFF_8000 fits, then 0x0000_8000 back-to-back does not
    in_valid = 1'b1; in_data = 32'hFFFF_8000;
    tick();
    check_beat("s2a", 16'h8000, 1'b1, 1'b1);
    check_val("s2a.cnt_short", 32'(cnt_short), 32'd2);
    check_val("s2a.in_ready", 32'(in_ready), 32'd1);
    in_data = 32'h0000_8000;
    tick();
    in_valid = 1'b0;
    check_beat("s2b.hi", 16'h0000, 1'b0, 1'b0);
    check_val("s2b.cnt_long", 32'(cnt_long), 32'd1);
    check_val("s2b.in_ready_hi", 32'(in_ready), 32'd0);
    tick();
    check_beat("s2b.lo", 16'h8000, 1'b0, 1'b1);
    tick();
    check_val("s2b.idle", 32'(out_valid), 32'd0);

    // 0xFFFF_7FFF does not fit
    in_valid = 1'b1; in_data = 32'hFFFF_7FFF;
    tick();
    in_valid = 1'b0;
    check_beat("s2c.hi", 16'hFFFF, 1'b0, 1'b0);
    tick();
    check_beat("s2c.lo", 16'h7FFF, 1'b0, 1'b1);
    check_val("s2c.cnt_long", 32'(cnt_long), 32'd2);
    tick();

    // back-to-back shorts
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      tick();
      check_beat("s3", 16'(i), 1'b1, 1'b1);
      check_val("s3.in_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check_val("s3.idle", 32'(out_valid), 32'd0);
    check_val("s3.cnt_short", 32'(cnt_short), 32'd5);

    // long word with backpressure in HI
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h1234_5678;
    tick();
    in_valid = 1'b0;
    check_beat("s4.hi", 16'h1234, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_beat("s4.hold", 16'h1234, 1'b0, 1'b0);
      check_val("s4.in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check_beat("s4.lo", 16'h5678, 1'b0, 1'b1);
    tick();
    check_val("s4.idle", 32'(out_valid), 32'd0);
    check_val("s4.cnt_long", 32'(cnt_long), 32'd3);

    // reset while in LO
    in_valid = 1'b1; in_data = 32'h1234_5678;
    tick();
    in_valid = 1'b0;
    tick();
    check_beat("s5.lo", 16'h5678, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check_val("s5.out_valid", 32'(out_valid), 32'd0);
    check_val("s5.cnt_short", 32'(cnt_short), 32'd0);
    check_val("s5.cnt_long",  32'(cnt_long),  32'd0);
    check_val("s5.out_data",  32'(out_data),  32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check_val("s5.in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("s5.no_beat", 32'(out_valid), 32'd0);
    end

    // compression disabled, 2-bit counters saturate
    out_ready2 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      in_valid2 = 1'b1; in_data2 = 32'(k);
      tick();
      in_valid2 = 1'b0;
      check_val("s6.hi.valid", 32'(out_valid2), 32'd1);
      check_val("s6.hi.data",  32'(out_data2),  32'h0000);
      check_val("s6.hi.short", 32'(out_short2), 32'd0);
      check_val("s6.hi.last",  32'(out_last2),  32'd0);
      check_val("s6.cnt_long", 32'(cnt_long2),  32'((k > 3) ? 3 : k));
      tick();
      check_val("s6.lo.data",  32'(out_data2),  32'(k));
      check_val("s6.lo.last",  32'(out_last2),  32'd1);
      check_val("s6.lo.short", 32'(out_short2), 32'd0);
      tick();
      check_val("s6.idle", 32'(out_valid2), 32'd0);
    end
    check_val("s6.cnt_short", 32'(cnt_short2), 32'd0);
    check_val("s6.in_ready", 32'(in_ready2), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
